// File: rtl/mult_unit.sv
// Iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Operands are reduced to magnitudes on accept, multiplied unsigned over
// DATA_W iterations, and the sign is re-applied to the full product on the
// final iteration before the requested half is captured.
module mult_unit #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned CNT_W  = 7
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              enable,
   input  logic              start,
   input  logic [2:0]        func3,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic              stall
);

   localparam int unsigned PROD_W = 2 * DATA_W;

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StDone
   } state_e;

   state_e              r_state;
   state_e              w_state_next;
   logic [CNT_W-1:0]    r_cnt;
   logic [PROD_W-1:0]   r_acc;
   // Multiplicand kept pre-shifted so each step only needs a 1-bit shift.
   logic [PROD_W-1:0]   r_mcand;
   logic [DATA_W-1:0]   r_mplier;
   logic                r_neg;
   logic [1:0]          r_sel;
   logic [DATA_W-1:0]   r_result;

   logic                w_sa;
   logic                w_sb;
   logic                w_a_neg;
   logic                w_b_neg;
   logic [DATA_W-1:0]   w_a_mag;
   logic [DATA_W-1:0]   w_b_mag;
   logic [1:0]          w_sel;
   logic [PROD_W-1:0]   w_acc_sum;
   logic [PROD_W-1:0]   w_prod;
   logic                w_last;

   // Operand sign handling and final-product formation.
   always_comb begin
      w_sa      = (func3 == 3'b001) || (func3 == 3'b010);
      w_sb      = (func3 == 3'b001);
      w_a_neg   = w_sa & op_a[DATA_W-1];
      w_b_neg   = w_sb & op_b[DATA_W-1];
      w_a_mag   = w_a_neg ? -op_a : op_a;
      w_b_mag   = w_b_neg ? -op_b : op_b;
      // Undefined codes (func3[2]=1) fall back to MUL, i.e. the low half.
      w_sel     = func3[2] ? 2'b00 : func3[1:0];
      w_acc_sum = r_acc + (r_mplier[0] ? r_mcand : '0);
      w_prod    = r_neg ? -w_acc_sum : w_acc_sum;
      w_last    = (r_cnt == CNT_W'(DATA_W - 1));
   end

   // Next-state logic for IDLE -> BUSY -> DONE -> IDLE.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle:  if (start) w_state_next = StBusy;
         StBusy:  if (w_last) w_state_next = StDone;
         StDone:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   // State register; frozen while enable is low.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state <= StIdle;
      end else if (enable) begin
         r_state <= w_state_next;
      end
   end

   // Datapath: operand latch on accept, one shift-add per BUSY cycle.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_neg    <= 1'b0;
         r_sel    <= 2'b00;
         r_result <= '0;
      end else if (enable) begin
         case (r_state)
            StIdle: begin
               if (start) begin
                  r_mcand  <= {{DATA_W{1'b0}}, w_a_mag};
                  r_mplier <= w_b_mag;
                  r_neg    <= w_a_neg ^ w_b_neg;
                  r_sel    <= w_sel;
                  r_acc    <= '0;
                  r_cnt    <= '0;
               end
            end
            StBusy: begin
               r_acc    <= w_acc_sum;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_result <= (r_sel == 2'b00) ? w_prod[DATA_W-1:0]
                                               : w_prod[PROD_W-1:DATA_W];
               end
            end
            default: ;
         endcase
      end
   end

   // Status outputs; stall also covers the accept cycle combinationally.
   always_comb begin
      busy   = (r_state != StIdle);
      done   = (r_state == StDone);
      result = r_result;
      stall  = busy | (start & (r_state == StIdle));
   end

endmodule

// File: tb/tb_mult_unit.sv
// Directed self-checking bench for mult_unit.
module tb_mult_unit;

   localparam int unsigned DATA_W = 64;

   logic              clk;
   logic              arst_n;
   logic              enable;
   logic              start;
   logic [2:0]        func3;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] result;
   logic              stall;

   int total;
   int bad;

   mult_unit #(
      .DATA_W(DATA_W),
      .CNT_W (7)
   ) u_dut (
      .clk   (clk),
      .arst_n(arst_n),
      .enable(enable),
      .start (start),
      .func3 (func3),
      .op_a  (op_a),
      .op_b  (op_b),
      .busy  (busy),
      .done  (done),
      .result(result),
      .stall (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1ns after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue a one-cycle start and follow the operation until busy drops.
   // Cycle 1 is the first cycle after the accepting edge.
   task automatic do_op(input logic [2:0] f3, input logic [DATA_W-1:0] a,
                        input logic [DATA_W-1:0] b, output logic [DATA_W-1:0] res,
                        output int done_cyc, output int n_done, output int n_busy);
      res      = '0;
      done_cyc = 0;
      n_done   = 0;
      n_busy   = 0;
      func3    = f3;
      op_a     = a;
      op_b     = b;
      start    = 1'b1;
      step();
      start = 1'b0;
      for (int i = 1; i <= 300; i++) begin
         if (done) begin
            n_done++;
            if (n_done == 1) begin
               done_cyc = i;
               res      = result;
            end
         end
         if (!busy) break;
         n_busy++;
         step();
      end
   endtask

   task automatic test_reset();
      arst_n = 1'b0;
      enable = 1'b1;
      start  = 1'b0;
      func3  = 3'b000;
      op_a   = '0;
      op_b   = '0;
      #12;
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || stall !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: busy=%b done=%b result=%h stall=%b, want 0/0/0/0",
                  busy, done, result, stall);
      end
      #4;
      arst_n = 1'b1;
      step();
   endtask

   task automatic test_mul_basic();
      logic [DATA_W-1:0] res;
      int dc, nd, nb;
      func3 = 3'b000;
      op_a  = 64'd3;
      op_b  = 64'd5;
      start = 1'b1;
      #1;
      total++;
      if (stall !== 1'b1) begin
         bad++;
         $display("FAIL mul_start_stall: got %b want 1", stall);
      end
      start = 1'b0;
      do_op(3'b000, 64'd3, 64'd5, res, dc, nd, nb);
      total++;
      if (res !== 64'h0000_0000_0000_000F) begin
         bad++;
         $display("FAIL mul_3x5: got %h want 000000000000000f", res);
      end
      total++;
      if (nb != 65) begin
         bad++;
         $display("FAIL mul_busy_len: got %0d want 65", nb);
      end
      total++;
      if (nd != 1 || dc != 65) begin
         bad++;
         $display("FAIL mul_done_pulse: count=%0d cycle=%0d want 1 at 65", nd, dc);
      end
   endtask

   task automatic test_signed_variants();
      logic [DATA_W-1:0] res;
      logic [DATA_W-1:0] ones;
      logic [DATA_W-1:0] minv;
      int dc, nd, nb;
      ones = '1;
      minv = 64'h8000_0000_0000_0000;
      do_op(3'b001, ones, ones, res, dc, nd, nb);
      total++;
      if (res !== 64'h0) begin
         bad++;
         $display("FAIL mulh_m1xm1: got %h want 0000000000000000", res);
      end
      do_op(3'b000, ones, ones, res, dc, nd, nb);
      total++;
      if (res !== 64'h1) begin
         bad++;
         $display("FAIL mul_m1xm1: got %h want 0000000000000001", res);
      end
      do_op(3'b011, ones, ones, res, dc, nd, nb);
      total++;
      if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin
         bad++;
         $display("FAIL mulhu_max: got %h want fffffffffffffffe", res);
      end
      do_op(3'b010, ones, 64'd2, res, dc, nd, nb);
      total++;
      if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         bad++;
         $display("FAIL mulhsu_m1x2: got %h want ffffffffffffffff", res);
      end
      do_op(3'b001, minv, minv, res, dc, nd, nb);
      total++;
      if (res !== 64'h4000_0000_0000_0000) begin
         bad++;
         $display("FAIL mulh_minxmin: got %h want 4000000000000000", res);
      end
      // -1 (signed) * 0xFFFF..FFFF (unsigned) = -(2^64-1); high half is all ones.
      do_op(3'b010, ones, ones, res, dc, nd, nb);
      total++;
      if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         bad++;
         $display("FAIL mulhsu_m1xmax: got %h want ffffffffffffffff", res);
      end
      // Undefined func3 code must act as MUL.
      do_op(3'b101, 64'h1_0000_0001, 64'd6, res, dc, nd, nb);
      total++;
      if (res !== 64'h6_0000_0006) begin
         bad++;
         $display("FAIL undef_func3_as_mul: got %h want 0000000600000006", res);
      end
   endtask

   // Follow an in-flight 7*9 MUL; optionally pulse start or drop enable.
   task automatic run_7x9(input bit pulse_start, input bit drop_en,
                          output logic [DATA_W-1:0] res, output int dc, output int nd);
      res   = '0;
      dc    = 0;
      nd    = 0;
      func3 = 3'b000;
      op_a  = 64'd7;
      op_b  = 64'd9;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 1; i <= 300; i++) begin
         if (pulse_start && i == 10) begin
            op_a  = 64'd100;
            start = 1'b1;
         end
         if (pulse_start && i == 11) start = 1'b0;
         if (drop_en && i == 20) enable = 1'b0;
         if (drop_en && i == 25) enable = 1'b1;
         if (done) begin
            nd++;
            if (nd == 1) begin
               dc  = i;
               res = result;
            end
         end
         if (!busy) break;
         step();
      end
   endtask

   task automatic test_robustness();
      logic [DATA_W-1:0] res;
      int dc, nd;
      run_7x9(1'b1, 1'b0, res, dc, nd);
      total++;
      if (res !== 64'd63 || dc != 65 || nd != 1) begin
         bad++;
         $display("FAIL start_ignored: result=%0d cyc=%0d n=%0d want 63 at 65 n=1",
                  res, dc, nd);
      end
      run_7x9(1'b0, 1'b1, res, dc, nd);
      total++;
      if (res !== 64'd63 || dc != 70 || nd != 1) begin
         bad++;
         $display("FAIL enable_freeze: result=%0d cyc=%0d n=%0d want 63 at 70 n=1",
                  res, dc, nd);
      end
   endtask

   task automatic test_back_to_back();
      int t1, t2, seen;
      t1    = 0;
      t2    = 0;
      seen  = 0;
      func3 = 3'b000;
      op_a  = 64'd2;
      op_b  = 64'd3;
      start = 1'b1;
      for (int i = 0; i <= 300; i++) begin
         if (done) begin
            seen++;
            if (seen == 1) t1 = i;
            if (seen == 2) begin
               t2    = i;
               start = 1'b0;
               break;
            end
         end
         step();
      end
      total++;
      if (t2 - t1 != 66 || result !== 64'd6) begin
         bad++;
         $display("FAIL back_to_back: spacing=%0d result=%0d want 66 and 6", t2 - t1, result);
      end
      step();
      step();
   endtask

   task automatic test_reset_mid_op();
      logic [DATA_W-1:0] res;
      int dc, nd, nb, spurious;
      spurious = 0;
      func3    = 3'b000;
      op_a     = 64'd5;
      op_b     = 64'd5;
      start    = 1'b1;
      step();
      start = 1'b0;
      for (int i = 1; i < 30; i++) step();
      #2;
      arst_n = 1'b0;
      #1;
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || stall !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_op: busy=%b done=%b result=%h stall=%b want 0/0/0/0",
                  busy, done, result, stall);
      end
      step();
      #3;
      arst_n = 1'b1;
      for (int i = 0; i < 80; i++) begin
         step();
         if (done || busy) spurious++;
      end
      total++;
      if (spurious != 0) begin
         bad++;
         $display("FAIL reset_no_done: active cycles after release=%0d want 0", spurious);
      end
      do_op(3'b000, 64'd2, 64'd2, res, dc, nd, nb);
      total++;
      if (res !== 64'd4 || nd != 1) begin
         bad++;
         $display("FAIL after_reset_2x2: got %0d n=%0d want 4 n=1", res, nd);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_mul_basic();
      test_signed_variants();
      test_robustness();
      test_back_to_back();
      test_reset_mid_op();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute time bound so the bench can never hang.
   initial begin
      #400000;
      $display("FAIL timeout: simulation exceeded time bound");
      $fatal(1, "timeout");
   end

endmodule
